parking_slot_controller: RTL
============================

// Module: parking_slot_controller
// PURPOSE
//  Owns the 4-slot lot state: arbitrates entry-gate and exit-gate requests, allocates the lowest
//  free slot, and runs a per-slot mm:ss parking timer. Drives mode/capacity/empty_slot/minutes/
//  seconds of multiplexed_display: shows occupancy normally and a car's parked time after it exits.
// PARAMETERS
//  NUM_SLOTS      4    number of parking slots; fixed at 4 (matches 2-bit slot ids, 3-bit capacity)
//  TICKS_PER_SEC  500  clk_500Hz cycles per one-second tick
//  SHOW_TIME_SEC  5    seconds the display stays in time mode after an exit
// PORTS
//  clk_500Hz     in   1  system clock, 500 Hz
//  reset         in   1  synchronous, active-high reset
//  entry_req     in   1  entry gate request, level, held until entry_ack/entry_nak
//  entry_ack     out  1  1-cycle pulse: slot granted
//  entry_nak     out  1  1-cycle pulse: lot full, request refused
//  entry_slot    out  2  granted slot index, valid while entry_ack=1
//  exit_req      in   1  exit gate request, level, held until exit_ack/exit_err
//  exit_slot_id  in   2  slot being vacated, stable while exit_req=1
//  exit_ack      out  1  1-cycle pulse: slot freed
//  exit_err      out  1  1-cycle pulse: exit_slot_id not occupied, no state change
//  full          out  1  1 when all slots occupied
//  mode          out  1  0 = capacity/slot display, 1 = time display
//  capacity      out  3  number of free slots, 0..4
//  empty_slot    out  2  lowest free slot index; 0 when full
//  minutes       out  6  parked minutes of last exited car, 0..59
//  seconds       out  6  parked seconds of last exited car, 0..59
// BEHAVIOUR
//  - Reset values: occupancy=0000, capacity=4, empty_slot=0, full=0, mode=0, minutes=seconds=0,
//    all ack/nak/err=0, entry_slot=0, FSM=IDLE, prescaler=0, all slot timers=00:00.
//    Reset mid-handshake aborts it. No pulse is issued for the aborted request.
//  - FSM IDLE -> GRANT -> WAIT_REL -> IDLE.
//    IDLE: samples requests on an edge. exit_req has priority over entry_req. Next state GRANT.
//    GRANT: exactly one cycle; asserts exactly one of entry_ack, entry_nak, exit_ack, exit_err.
//    Occupancy, capacity, empty_slot and full take their new values on the same edge that
//    raises the pulse. Latency: req seen at edge n -> pulse high during cycle n+1 -> n+2.
//    WAIT_REL: holds until the served req is low, then returns to IDLE.
//    The other gate's request stays pending and is served on the next IDLE pass.
//  - Simultaneous entry+exit while full: exit first (frees slot), then the entry is granted that slot.
//  - Entry: lowest-index free slot; slot timer cleared to 00:00 and starts counting.
//    If full -> entry_nak, no change.
//  - Exit of occupied slot: latch that slot's timer into minutes/seconds, clear slot, set mode=1,
//    load show counter=SHOW_TIME_SEC. Show counter decrements on each 1 s tick; at 0 -> mode=0.
//    A new exit during time mode reloads the counter and overwrites minutes/seconds.
//    Entry/nak/err leave mode unchanged.
//  - Tick: prescaler counts 0..TICKS_PER_SEC-1. Tick asserted 1 cycle at wrap.
//    Prescaler is free-running, not resynced by grants.
//  - Slot timer: seconds 0..59 wraps and carries to minutes; saturates at 59:59.
//    Occupied slots only; a free slot holds 00:00.
//  - capacity = NUM_SLOTS - popcount(occupancy); full = (capacity==0).
//  - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared header parking_pkg: NUM_SLOTS, SLOT_W=2, CAP_W=3, MAX_MIN=59, MAX_SEC=59,
//    and FSM state encodings IDLE/GRANT/WAIT_REL.
//  - Sub-module slot_timer, instantiated NUM_SLOTS times.
//    Ports: clk_500Hz, reset, clear, run, tick -> minutes[5:0], seconds[5:0]; saturating mm:ss counter.
//  - Top holds: FSM, occupancy register, priority encoder (lowest free slot),
//    popcount, prescaler, show counter.
// TESTING (bench overrides TICKS_PER_SEC=5, SHOW_TIME_SEC=2)
//  1. Reset, then 4 entries, each req dropped after its ack -> entry_slot 0,1,2,3;
//     capacity 3,2,1,0; full=1 after the 4th.
//  2. 5th entry while full -> entry_nak pulse; capacity stays 0; occupancy unchanged.
//  3. Full lot; assert entry_req and exit_req (slot 2) in the same cycle ->
//     exit_ack first, then entry_ack with entry_slot=2; capacity ends at 0.
//  4. Enter slot 0, wait 65 ticks, exit slot 0 -> minutes=1, seconds=5, mode=1;
//     mode=0 after 2 further ticks.
//  5. exit_slot_id=3 while slot 3 is free -> exit_err pulse; capacity, mode, minutes unchanged.
//  6. Assert reset during WAIT_REL with a 3000-second-old car parked -> all outputs at reset values
//     next cycle. Separately, a slot held 3700 ticks reads 59:59 on exit (saturation).

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants, FSM encoding and small combinational helpers for the
// parking lot controller and its per-slot timers.
package parking_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int CAP_W     = 3;
    localparam int MAX_MIN   = 59;
    localparam int MAX_SEC   = 59;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    function automatic logic [CAP_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [CAP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt + CAP_W'(v[i]);
        end
        return cnt;
    endfunction

    // Lowest-index free slot; 0 when every slot is taken.
    function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
        logic [SLOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) idx = SLOT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot mm:ss parking timer; counts one second per tick while run is high
// and saturates at 59:59. clear wins over counting.
module slot_timer
    import parking_pkg::*;
(
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic       tick,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);

    always_ff @(posedge clk_500Hz) begin
        if (reset || clear) begin
            minutes <= '0;
            seconds <= '0;
        end else if (run && tick) begin
            if (seconds == 6'(MAX_SEC)) begin
                if (minutes != 6'(MAX_MIN)) begin
                    seconds <= '0;
                    minutes <= minutes + 6'd1;
                end
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_controller.sv
// Four-slot lot controller: serves entry/exit gate requests one at a time,
// tracks occupancy and per-slot parked time, and drives the display fields.
module parking_slot_controller
    import parking_pkg::*;
#(
    parameter int TICKS_PER_SEC = 500,
    parameter int SHOW_TIME_SEC = 5
) (
    input  logic              clk_500Hz,
    input  logic              reset,
    input  logic              entry_req,
    output logic              entry_ack,
    output logic              entry_nak,
    output logic [SLOT_W-1:0] entry_slot,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot_id,
    output logic              exit_ack,
    output logic              exit_err,
    output logic              full,
    output logic              mode,
    output logic [CAP_W-1:0]  capacity,
    output logic [SLOT_W-1:0] empty_slot,
    output logic [5:0]        minutes,
    output logic [5:0]        seconds,
    output logic [1:0]        fsm_state
);

    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SHOW_W  = $clog2(SHOW_TIME_SEC + 1) + 1;

    // Handshake: a gate raises its req (level) and holds it until it sees its
    // 1-cycle ack/nak/err; the FSM then waits for that req to drop before
    // serving anything else, so one request yields exactly one pulse.
    state_t                state, state_next;
    logic                  serve_exit;
    logic [SLOT_W-1:0]     serve_slot;
    logic [NUM_SLOTS-1:0]  occupancy, occ_next, timer_clear;
    logic [PRESC_W-1:0]    presc;
    logic [SHOW_W-1:0]     show_cnt;
    logic                  tick;
    logic                  do_entry, do_nak, do_exit, do_err;
    logic [5:0]            tmr_min [NUM_SLOTS];
    logic [5:0]            tmr_sec [NUM_SLOTS];

    assign tick      = (presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign fsm_state = state;

    always_comb begin
        state_next  = state;
        do_entry    = 1'b0;
        do_nak      = 1'b0;
        do_exit     = 1'b0;
        do_err      = 1'b0;
        occ_next    = occupancy;
        timer_clear = '0;
        case (state)
            IDLE:     if (exit_req || entry_req) state_next = GRANT;
            GRANT: begin
                state_next = WAIT_REL;
                if (serve_exit) begin
                    do_exit = occupancy[serve_slot];
                    do_err  = !occupancy[serve_slot];
                end else begin
                    do_entry = !full;
                    do_nak   = full;
                end
            end
            WAIT_REL: if (!(serve_exit ? exit_req : entry_req)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (do_entry) occ_next[empty_slot] = 1'b1;
        if (do_exit)  occ_next[serve_slot] = 1'b0;
        // An exiting slot is cleared too, so a free slot always reads 00:00.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            timer_clear[i] = (do_entry && empty_slot == SLOT_W'(i)) ||
                             (do_exit && serve_slot == SLOT_W'(i));
        end
    end

    always_ff @(posedge clk_500Hz) begin
        if (reset) begin
            state      <= IDLE;
            serve_exit <= 1'b0;
            serve_slot <= '0;
            occupancy  <= '0;
            capacity   <= CAP_W'(NUM_SLOTS);
            empty_slot <= '0;
            full       <= 1'b0;
            entry_ack  <= 1'b0;
            entry_nak  <= 1'b0;
            exit_ack   <= 1'b0;
            exit_err   <= 1'b0;
            entry_slot <= '0;
            presc      <= '0;
            show_cnt   <= '0;
            mode       <= 1'b0;
            minutes    <= '0;
            seconds    <= '0;
        end else begin
            state <= state_next;
            // Exit is latched first so it wins a same-edge collision with entry.
            if (state == IDLE) begin
                serve_exit <= exit_req;
                serve_slot <= exit_slot_id;
            end
            entry_ack  <= do_entry;
            entry_nak  <= do_nak;
            exit_ack   <= do_exit;
            exit_err   <= do_err;
            if (do_entry) entry_slot <= empty_slot;
            occupancy  <= occ_next;
            capacity   <= CAP_W'(NUM_SLOTS) - popcount(occ_next);
            full       <= &occ_next;
            empty_slot <= lowest_free(occ_next);
            presc      <= tick ? '0 : presc + PRESC_W'(1);
            if (do_exit) begin
                mode     <= 1'b1;
                show_cnt <= SHOW_W'(SHOW_TIME_SEC);
                minutes  <= tmr_min[serve_slot];
                seconds  <= tmr_sec[serve_slot];
            end else if (tick && show_cnt != '0) begin
                show_cnt <= show_cnt - SHOW_W'(1);
                if (show_cnt == SHOW_W'(1)) mode <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_timer u_timer (
            .clk_500Hz (clk_500Hz),
            .reset     (reset),
            .clear     (timer_clear[g]),
            .run       (occupancy[g]),
            .tick      (tick),
            .minutes   (tmr_min[g]),
            .seconds   (tmr_sec[g])
        );
    end

endmodule
